serial_tx: RTL



---
 rtl/serial_tx_pkg.sv | 23 ++
 rtl/serial_tx_if.sv | 28 ++
 rtl/serial_tx_baud_counter.sv | 29 ++
 rtl/serial_tx.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial transmitter.
//   tx_state_t       : transmitter FSM states
//   DATA_W_DEF       : default data bits per frame
//   CLKS_PER_BIT_DEF : default clock cycles per serial bit
//   frame_bits()     : frame length in bit times (start + data + [parity] + stop)
package serial_pkg;

  localparam int unsigned DATA_W_DEF       = 8;
  localparam int unsigned CLKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int unsigned frame_bits(input int unsigned data_w, input bit parity);
    return data_w + 32'd2 + (parity ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Producer-side valid/ready word handshake of the serial transmitter.
//   din       : word to transmit
//   din_valid : producer has a word on din
//   din_ready : transmitter can accept a word
// master = word producer, slave = transmitter.
interface serial_tx_if
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );

endinterface

// File: rtl/serial_tx_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and wraps; clr restarts it at 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count on the next edge
//   tick       : count is at CLKS_PER_BIT-1 (last cycle of a bit time)
//   count      : current position within the bit time
module baud_counter #(
  parameter  int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit. Line idles high.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : valid/ready word input (din, din_valid, din_ready)
//   dout       : registered serial line
//   busy       : frame in progress (inverse of din_ready)
// Build option: define SERIAL_TX_PARITY_EN to insert the parity bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  serial_tx_if.slave  bus,
  output logic        dout,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W) + 1;

  tx_state_t         state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_next_c;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  count;
  logic              tick;
  logic              clr_c;
  logic              accept_c;
  logic              last_bit_c;
  logic              stop_end_c;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .tick  (tick),
    .count (count)
  );

  // The stop state ends one cycle early so the IDLE cycle that follows
  // completes the stop bit; an accept on that cycle's closing edge starts
  // the next frame with no gap on the line.
  always_comb begin
    sh_next_c  = shreg >> 1;
    accept_c   = bus.din_ready & bus.din_valid;
    last_bit_c = (bit_idx == IDX_W'(DATA_W - 1));
    stop_end_c = (count == CNT_W'(CLKS_PER_BIT - 2));
    clr_c      = 1'b0;
    case (state)
      IDLE:   clr_c = accept_c;
      START:  clr_c = tick;
      DATA:   clr_c = tick & last_bit_c;
`ifdef SERIAL_TX_PARITY_EN
      PARITY: clr_c = tick;
`else
      PARITY: clr_c = 1'b1;
`endif
      STOP:   clr_c = stop_end_c;
      default: clr_c = 1'b1;
    endcase
  end

  // Frame sequencer; dout is set to the value of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      bit_idx       <= '0;
      dout          <= 1'b1;
      bus.din_ready <= 1'b1;
      busy          <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            state         <= START;
            shreg         <= bus.din;
            bit_idx       <= '0;
            dout          <= 1'b0;
            bus.din_ready <= 1'b0;
            busy          <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par           <= ^bus.din;
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            dout  <= shreg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= sh_next_c;
            if (last_bit_c) begin
              bit_idx <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state   <= PARITY;
              dout    <= par;
`else
              state   <= STOP;
              dout    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              dout    <= sh_next_c[0];
            end
          end
        end
        PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
          if (tick) begin
            state <= STOP;
            dout  <= 1'b1;
          end
`else
          state         <= IDLE;
          dout          <= 1'b1;
          bus.din_ready <= 1'b1;
          busy          <= 1'b0;
`endif
        end
        STOP: begin
          if (stop_end_c) begin
            state         <= IDLE;
            bus.din_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          dout          <= 1'b1;
          bus.din_ready <= 1'b1;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule
